// File: rtl/audioqsys_keys_in.sv
// Avalon-MM push-button / switch input port.
// Two-flop sync, per-bit debounce, edge capture and maskable level IRQ.
module audioqsys_keys_in #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter int unsigned      EDGE_TYPE       = 2,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] ec_q;
    logic [WIDTH-1:0] ec_d;
    logic [WIDTH-1:0] edge_w;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // Input synchroniser, debounce state and the previous debounced copy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
            deb_q   <= RESET_LEVEL;
            prev_q  <= RESET_LEVEL;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            prev_q  <= deb_q;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Per-bit stability counter; a bit is accepted after a full unbroken run
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Qualify debounced transitions by the configured edge sense
    always_comb begin
        edge_w = '0;
        if (EDGE_TYPE == 0) begin
            edge_w = deb_q ^ prev_q;
        end else if (EDGE_TYPE == 1) begin
            edge_w = deb_q & ~prev_q;
        end else begin
            edge_w = ~deb_q & prev_q;
        end
    end

    // Register-file next state; a fresh edge overrides a same-cycle clear
    always_comb begin
        mask_d = mask_q;
        ec_d   = ec_q;
        if (wr_en && address == 2'd2) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd3) begin
            ec_d = ec_q & ~writedata[WIDTH-1:0];
        end
        ec_d = ec_d | edge_w;
    end

    // Interrupt mask and sticky edge capture registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            ec_q   <= '0;
        end else begin
            mask_q <= mask_d;
            ec_q   <= ec_d;
        end
    end

    // Zero-wait-state read mux, no side effects
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = 32'(deb_q);
            2'd2:    readdata = 32'(mask_q);
            2'd3:    readdata = 32'(ec_q);
            default: readdata = '0;
        endcase
    end

    assign irq = |(ec_q & mask_q);

endmodule

// File: tb/tb_audioqsys_keys_in.sv
// Testbench for audioqsys_keys_in: falling-edge and any-edge instances
// share stimulus; a scoreboard queue is drained by a read monitor.
module tb_audioqsys_keys_in;

    localparam int DC = 4;

    typedef struct {
        logic [31:0] r0;
        logic [31:0] r1;
        logic        i0;
        logic        i1;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        irq0;
    logic        irq1;
    logic        rd_req;

    int checks = 0;
    int errors = 0;

    exp_t  exp_q  [$];
    string name_q [$];

    // reference model state
    logic [3:0] hist [$];
    logic [3:0] seen [$];
    logic [3:0] m_deb;
    logic [3:0] m_prev;
    logic [3:0] m_mask;
    logic [3:0] m_ec0;
    logic [3:0] m_ec1;

    audioqsys_keys_in #(
        .WIDTH(4), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(2)
    ) u_fall (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd0),
        .in_port(in_port), .irq(irq0)
    );

    audioqsys_keys_in #(
        .WIDTH(4), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(0)
    ) u_any (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd1),
        .in_port(in_port), .irq(irq1)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        hist.delete();
        seen.delete();
        hist.push_back(4'hF);
        hist.push_back(4'hF);
        m_deb  = 4'hF;
        m_prev = 4'hF;
        m_mask = 4'h0;
        m_ec0  = 4'h0;
        m_ec1  = 4'h0;
    endtask

    // A bit flips once the last DC synchronised samples all disagree with it.
    task automatic model_step();
        logic [3:0] clr;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] nd;
        bit         all_diff;
        if (reset) begin
            model_reset();
            return;
        end
        clr = (chipselect && !write_n && address == 2'd3) ?
              writedata[3:0] : 4'h0;
        rise  = m_deb & ~m_prev;
        fall  = ~m_deb & m_prev;
        m_ec0 = (m_ec0 & ~clr) | fall;
        m_ec1 = (m_ec1 & ~clr) | rise | fall;
        if (chipselect && !write_n && address == 2'd2)
            m_mask = writedata[3:0];
        hist.push_back(in_port);
        seen.push_back(hist[hist.size() - 3]);
        while (hist.size() > 3) void'(hist.pop_front());
        while (seen.size() > DC) void'(seen.pop_front());
        nd = m_deb;
        if (seen.size() == DC) begin
            for (int b = 0; b < 4; b++) begin
                all_diff = 1'b1;
                foreach (seen[j])
                    if (seen[j][b] == m_deb[b]) all_diff = 1'b0;
                if (all_diff) nd[b] = ~m_deb[b];
            end
        end
        m_prev = m_deb;
        m_deb  = nd;
    endtask

    function automatic logic [31:0] m_rd(input logic [1:0] a,
                                         input bit inst);
        case (a)
            2'd0:    return {28'h0, m_deb};
            2'd2:    return {28'h0, m_mask};
            2'd3:    return {28'h0, inst ? m_ec1 : m_ec0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_irq(input bit inst);
        return |((inst ? m_ec1 : m_ec0) & m_mask);
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        rd_req = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d,
                      input logic cs);
        address    = a;
        writedata  = d;
        chipselect = cs;
        write_n    = 1'b0;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rdx(input string n, input logic [1:0] a,
                       input logic [31:0] e0, input logic ei0,
                       input logic [31:0] e1, input logic ei1);
        exp_t e;
        address    = a;
        write_n    = 1'b1;
        chipselect = 1'($urandom_range(0, 1));
        e.r0 = e0;
        e.i0 = ei0;
        e.r1 = e1;
        e.i1 = ei1;
        exp_q.push_back(e);
        name_q.push_back(n);
        rd_req = 1'b1;
    endtask

    task automatic rdc(input string n, input logic [1:0] a,
                       input logic [31:0] e0, input logic ei0);
        rdx(n, a, e0, ei0, m_rd(a, 1'b1), m_irq(1'b1));
    endtask

    task automatic rdm(input string n, input logic [1:0] a);
        rdx(n, a, m_rd(a, 1'b0), m_irq(1'b0), m_rd(a, 1'b1), m_irq(1'b1));
    endtask

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, got, exp);
        end
    endtask

    // monitor: compare whenever a read is being presented
    always @(negedge clk) begin
        if (rd_req) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: read with no expectation");
            end else begin
                exp_t  e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                chk({n, "/fall_rd"},  rd0, e.r0);
                chk({n, "/fall_irq"}, {31'h0, irq0}, {31'h0, e.i0});
                chk({n, "/any_rd"},   rd1, e.r1);
                chk({n, "/any_irq"},  {31'h0, irq1}, {31'h0, e.i1});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        in_port    = 4'hF;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        rd_req     = 1'b0;
        model_reset();
        repeat (3) cyc();
        reset = 1'b0;

        // reset state
        cyc(); rdc("rst_data", 2'd0, 32'hF, 1'b0);
        cyc(); rdc("rst_rsvd", 2'd1, 32'h0, 1'b0);
        cyc(); rdc("rst_mask", 2'd2, 32'h0, 1'b0);
        cyc(); rdc("rst_ec",   2'd3, 32'h0, 1'b0);

        // clean press of bit 0
        cyc(); in_port = 4'hE;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            rdc("press_data", 2'd0, (k < 6) ? 32'hF : 32'hE, 1'b0);
        end
        cyc(); rdc("press_ec", 2'd3, 32'h1, 1'b0);

        // bounce on bit 1
        for (int k = 0; k < 8; k++) begin
            cyc();
            in_port = (k == 3 || k == 7) ? 4'hE : 4'hC;
            rdc("bounce_data", 2'd0, 32'hE, 1'b0);
        end
        for (int k = 0; k < 8; k++) begin
            cyc(); rdc("bounce_hold", 2'd0, 32'hE, 1'b0);
        end
        cyc(); rdc("bounce_ec", 2'd3, 32'h1, 1'b0);

        cyc(); wr(2'd3, 32'hF, 1'b1);
        rdc("clr_ec", 2'd3, 32'h0, 1'b0);

        // release of bit 0: rising edge only seen by the any-edge port
        cyc(); in_port = 4'hF;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            rdc("rel_data", 2'd0, (k < 6) ? 32'hE : 32'hF, 1'b0);
        end
        cyc(); rdx("rel_ec", 2'd3, 32'h0, 1'b0, 32'h1, 1'b0);
        cyc(); rdc("rel_ec_hold", 2'd3, 32'h0, 1'b0);

        // irq flow
        cyc(); wr(2'd2, 32'h1, 1'b1);
        rdx("irq_mask", 2'd2, 32'h1, 1'b0, 32'h1, 1'b1);
        cyc(); in_port = 4'hE;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            rdc("irq_wait", 2'd3, (k < 7) ? 32'h0 : 32'h1, k == 7);
        end
        cyc(); wr(2'd3, 32'h2, 1'b1);
        rdc("w1c_other", 2'd3, 32'h1, 1'b1);
        cyc(); wr(2'd3, 32'h1, 1'b1);
        rdc("w1c_clr", 2'd3, 32'h0, 1'b0);

        // new edge on bit 2 lands in the same cycle as its W1C
        cyc(); in_port = 4'hA;
        for (int k = 1; k <= 5; k++) begin
            cyc(); rdc("coll_wait", 2'd0, 32'hE, 1'b0);
        end
        cyc();
        wr(2'd3, 32'h4, 1'b1);
        rdc("coll_ec", 2'd3, 32'h4, 1'b0);
        cyc(); rdc("coll_data", 2'd0, 32'hA, 1'b0);
        cyc(); wr(2'd3, 32'h4, 1'b1);
        rdc("coll_clr", 2'd3, 32'h0, 1'b0);

        // reset mid-count on bit 3
        cyc(); in_port = 4'h2;
        repeat (3) cyc();
        reset   = 1'b1;
        in_port = 4'hF;
        model_reset();
        rdc("rst2_in", 2'd0, 32'hF, 1'b0);
        cyc(); cyc();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            rdc("rst2_regs", 2'(k % 4), (k % 4 == 0) ? 32'hF : 32'h0, 1'b0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            int op;
            cyc();
            if ($urandom_range(0, 5) == 0)
                in_port = in_port ^ (4'b1 << $urandom_range(0, 3));
            op = int'($urandom_range(0, 9));
            if (op < 3) begin
                wr(2'($urandom_range(0, 3)), $urandom, 1'b1);
            end else if (op == 3) begin
                wr(2'($urandom_range(0, 3)), $urandom, 1'b0);
            end
            rdm("rand", 2'($urandom_range(0, 3)));
        end

        cyc(); cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d reads left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
